// File: rtl/data_mmio_responder.sv
// Memory-mapped register block on the CPU data port: LEDs, synchronised switches,
// a free-running timer with compare interrupt, and a scratch word.
module data_mmio_responder #(
   parameter logic [15:0] BASE_ADDR = 16'hBFAF,
   parameter int          LED_W     = 16,
   parameter int          SW_W      = 8
) (
   input  logic             cpu_clk_50M,
   input  logic             cpu_rst,
   input  logic             dce,
   input  logic [3:0]       we,
   input  logic [31:0]      daddr,
   input  logic [31:0]      din,
   output logic [31:0]      dm,
   output logic [LED_W-1:0] led,
   input  logic [SW_W-1:0]  sw,
   output logic             timer_irq
);

   localparam logic [13:0] IDX_LED     = 14'd0;
   localparam logic [13:0] IDX_SWITCH  = 14'd1;
   localparam logic [13:0] IDX_TIMER   = 14'd2;
   localparam logic [13:0] IDX_COMPARE = 14'd3;
   localparam logic [13:0] IDX_CTRL    = 14'd4;
   localparam logic [13:0] IDX_STATUS  = 14'd5;
   localparam logic [13:0] IDX_SCRATCH = 14'd6;

   logic [LED_W-1:0] led_reg;
   logic [SW_W-1:0]  sync1_reg, sync2_reg;
   logic [31:0]      timer_reg, compare_reg, scratch_reg, dm_reg;
   logic             ten_reg, irq_en_reg, irq_pending_reg;

   logic        hit, wr_any, wr_timer, irq_event, irq_clear;
   logic [13:0] idx;
   logic [31:0] wmask, timer_inc, timer_next, rd_data, dm_next;
   logic [1:0]  unused_addr;

   assign hit         = dce && (daddr[31:16] == BASE_ADDR);
   assign idx         = daddr[15:2];
   assign unused_addr = daddr[1:0];
   assign wr_any      = hit && (we != 4'b0000);
   assign wr_timer    = wr_any && (idx == IDX_TIMER);
   assign timer_inc   = ten_reg ? timer_reg + 32'd1 : timer_reg;
   // Compare uses the pre-increment count; the pending flag appears one cycle later.
   assign irq_event   = ten_reg && (timer_reg == compare_reg);
   assign irq_clear   = wr_any && (idx == IDX_STATUS) && we[0] && din[0];

   // Written timer bytes load directly; the rest follow the increment.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign wmask[8*gi +: 8]      = {8{we[gi]}};
         assign timer_next[8*gi +: 8] = (wr_timer && we[gi]) ? din[8*gi +: 8]
                                                             : timer_inc[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (idx)
            IDX_LED:     rd_data[LED_W-1:0] = led_reg;
            IDX_SWITCH:  rd_data[SW_W-1:0]  = sync2_reg;
            IDX_TIMER:   rd_data = timer_reg;
            IDX_COMPARE: rd_data = compare_reg;
            IDX_CTRL:    rd_data[1:0] = {irq_en_reg, ten_reg};
            IDX_STATUS:  rd_data[0] = irq_pending_reg;
            IDX_SCRATCH: rd_data = scratch_reg;
            default:     rd_data = '0;
         endcase
      end
   end

   // Write cycles return zero; idle cycles hold the previous read data.
   always_comb begin
      dm_next = dm_reg;
      if (dce) begin
         dm_next = (we != 4'b0000) ? 32'h0 : rd_data;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         led_reg         <= '0;
         sync1_reg       <= '0;
         sync2_reg       <= '0;
         timer_reg       <= '0;
         compare_reg     <= '0;
         scratch_reg     <= '0;
         dm_reg          <= '0;
         ten_reg         <= 1'b0;
         irq_en_reg      <= 1'b0;
         irq_pending_reg <= 1'b0;
      end else begin
         sync1_reg <= sw;
         sync2_reg <= sync1_reg;
         timer_reg <= timer_next;
         dm_reg    <= dm_next;
         if (wr_any && idx == IDX_LED) begin
            led_reg <= (led_reg & ~wmask[LED_W-1:0]) | (din[LED_W-1:0] & wmask[LED_W-1:0]);
         end
         if (wr_any && idx == IDX_COMPARE) begin
            compare_reg <= (compare_reg & ~wmask) | (din & wmask);
         end
         if (wr_any && idx == IDX_SCRATCH) begin
            scratch_reg <= (scratch_reg & ~wmask) | (din & wmask);
         end
         if (wr_any && idx == IDX_CTRL && we[0]) begin
            ten_reg    <= din[0];
            irq_en_reg <= din[1];
         end
         // A compare event outranks a simultaneous clear.
         if (irq_event) begin
            irq_pending_reg <= 1'b1;
         end else if (irq_clear) begin
            irq_pending_reg <= 1'b0;
         end
      end
   end

   assign dm        = dm_reg;
   assign led       = led_reg;
   assign timer_irq = irq_pending_reg & irq_en_reg;

endmodule

// File: tb/tb_data_mmio_responder.sv
// Directed bench for data_mmio_responder: a word-image model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_data_mmio_responder;

   logic        clk = 1'b0;
   logic        rst, dce, timer_irq;
   logic [3:0]  we;
   logic [31:0] daddr, din, dm;
   logic [15:0] led;
   logic [7:0]  sw;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   data_mmio_responder #(.BASE_ADDR(16'hBFAF), .LED_W(16), .SW_W(8)) dut (
      .cpu_clk_50M(clk), .cpu_rst(rst), .dce(dce), .we(we), .daddr(daddr),
      .din(din), .dm(dm), .led(led), .sw(sw), .timer_irq(timer_irq)
   );

   // Model: word image indexed by offset/4 (0 LED, 2 TIMER, 3 COMPARE, 4 CTRL, 5 STATUS, 6 SCRATCH).
   logic [31:0] mw [0:7];
   logic [7:0]  ms1, ms2;
   logic [31:0] m_dm;

   always @(posedge clk) begin
      logic        hit, ev;
      logic [13:0] ix;
      logic [31:0] bm, rdv, tnew;
      if (rst) begin
         for (int i = 0; i < 8; i++) mw[i] = 32'h0;
         ms1 = 8'h0; ms2 = 8'h0; m_dm = 32'h0;
      end else begin
         hit = dce && (daddr[31:16] == 16'hBFAF);
         ix  = daddr[15:2];
         bm  = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
         rdv = 32'h0;
         if (hit && ix == 14'd1) rdv = {24'h0, ms2};
         else if (hit && ix < 14'd7) rdv = mw[ix];
         ev   = mw[4][0] && (mw[2] == mw[3]);
         tnew = mw[2] + {31'h0, mw[4][0]};
         if (hit && we != 4'h0) begin
            case (ix)
               14'd0: mw[0] = ((mw[0] & ~bm) | (din & bm)) & 32'h0000FFFF;
               14'd2: tnew  = (tnew & ~bm) | (din & bm);
               14'd3: mw[3] = (mw[3] & ~bm) | (din & bm);
               14'd4: if (we[0]) mw[4] = din & 32'h3;
               14'd5: if (we[0] && din[0]) mw[5] = 32'h0;
               14'd6: mw[6] = (mw[6] & ~bm) | (din & bm);
               default: ;
            endcase
         end
         if (ev) mw[5] = 32'h1;
         mw[2] = tnew;
         if (dce) m_dm = (we != 4'h0) ? 32'h0 : rdv;
         ms2 = ms1;
         ms1 = sw;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_dm", dm, m_dm);
         check("model_led", {16'h0, led}, mw[0]);
         check("model_irq", {31'h0, timer_irq}, {31'h0, mw[5][0] & mw[4][1]});
      end
   end

   function automatic logic [31:0] ra(input logic [15:0] off);
      return {16'hBFAF, off};
   endfunction

   // All tasks start and end at posedge+2.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      dce = 1'b1; we = w; daddr = a; din = d;
      @(posedge clk); #2;
      dce = 1'b0; we = 4'h0;
      $display("wr  addr=%h data=%h we=%b", a, d, w);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] q);
      dce = 1'b1; we = 4'h0; daddr = a;
      @(posedge clk); #2;
      dce = 1'b0;
      q = dm;
      $display("rd  addr=%h dm=%h", a, q);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   initial begin
      logic [31:0] q;
      rst = 1'b1; dce = 1'b0; we = 4'h0; daddr = 32'h0; din = 32'h0; sw = 8'h0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0; chk_en = 1'b1;

      rd(ra(16'h00), q); check("rst_led_rd", q, 32'h0);
      rd(ra(16'h08), q); check("rst_timer_rd", q, 32'h0);
      rd(ra(16'h10), q); check("rst_ctrl_rd", q, 32'h0);
      rd(ra(16'h14), q); check("rst_status_rd", q, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_irq", {31'h0, timer_irq}, 32'h0);

      wr(ra(16'h00), 32'h1234ABCD, 4'b0001);
      check("led_byte0", {16'h0, led}, 32'h000000CD);
      wr(ra(16'h00), 32'h1234ABCD, 4'b0010);
      check("led_byte1", {16'h0, led}, 32'h0000ABCD);
      rd(ra(16'h00), q); check("led_rd", q, 32'h0000ABCD);
      rd(ra(16'h1C), q); check("unmapped_rd", q, 32'h0);

      sw = 8'hA5;
      rd(ra(16'h04), q); check("sw_early", q, 32'h0);
      idle(1);
      rd(ra(16'h04), q); check("sw_sync", q, 32'h000000A5);

      wr(ra(16'h08), 32'h0, 4'hF);
      wr(ra(16'h0C), 32'h5, 4'hF);
      wr(ra(16'h10), 32'h3, 4'hF);
      idle(5);
      check("irq_before", {31'h0, timer_irq}, 32'h0);
      idle(1);
      check("irq_rise", {31'h0, timer_irq}, 32'h1);
      wr(ra(16'h14), 32'h1, 4'b0001);
      check("irq_w1c", {31'h0, timer_irq}, 32'h0);
      idle(4);
      check("irq_no_reset", {31'h0, timer_irq}, 32'h0);

      wr(ra(16'h10), 32'h2, 4'hF);
      wr(ra(16'h08), 32'h20, 4'hF);
      wr(ra(16'h0C), 32'h22, 4'hF);
      wr(ra(16'h10), 32'h3, 4'hF);
      idle(2);
      wr(ra(16'h14), 32'h1, 4'b0001);
      check("set_wins", {31'h0, timer_irq}, 32'h1);
      wr(ra(16'h14), 32'h1, 4'b0001);
      check("clear_after", {31'h0, timer_irq}, 32'h0);

      wr(ra(16'h10), 32'h1, 4'hF);
      wr(ra(16'h08), 32'hFFFFFFFE, 4'hF);
      rd(ra(16'h08), q); check("wrap_fe", q, 32'hFFFFFFFE);
      rd(ra(16'h08), q); check("wrap_ff", q, 32'hFFFFFFFF);
      rd(ra(16'h08), q); check("wrap_0", q, 32'h0);
      wr(ra(16'h08), 32'h100, 4'hF);
      rd(ra(16'h08), q); check("timer_wr_prio", q, 32'h100);
      wr(ra(16'h08), 32'hAA, 4'b0001);
      rd(ra(16'h08), q); check("timer_partial", q, 32'h1AA);

      wr(ra(16'h10), 32'h0, 4'hF);
      wr(ra(16'h08), 32'h77, 4'hF);
      wr(32'h80000008, 32'hFFFFFFFF, 4'hF);
      check("miss_dm", dm, 32'h0);
      rd(ra(16'h08), q); check("miss_timer", q, 32'h77);
      idle(3);
      check("dm_hold", dm, 32'h77);
      rd(32'hBFAE0008, q); check("miss_rd", q, 32'h0);

      wr(ra(16'h18), 32'hDEADBEEF, 4'hF);
      check("wr_dm_zero", dm, 32'h0);
      wr(ra(16'h18), 32'h00550000, 4'b0100);
      rd(ra(16'h18), q); check("scratch_rd", q, 32'hDE55BEEF);

      rst = 1'b1; dce = 1'b1; we = 4'hF; daddr = ra(16'h18); din = 32'h12345678;
      @(posedge clk); #2;
      rst = 1'b0; dce = 1'b0; we = 4'h0;
      check("rst_mid_dm", dm, 32'h0);
      check("rst_mid_led", {16'h0, led}, 32'h0);
      rd(ra(16'h18), q); check("rst_mid_scratch", q, 32'h0);

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
